uart_hash_framer: RTL and testbench
===================================

UART_HASH_FRAMER -- requirements
Module: uart_hash_framer

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 64, message block size in bytes.
REQ-002 SHALL have parameter LEN_BYTES, default 8, length-field size appended at the end of the final block.
REQ-003 SHALL have parameter DIGEST_BYTES, default 16, digest size returned by the core.
REQ-004 SHALL have parameter TERM, default 24'h454F46 ("EOF"), 3-byte end-of-message terminator.
REQ-005 SHALL have port clk  in  1  master clock.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports received (in, 1, rx byte strobe) and rx_byte (in, 8, received byte).
REQ-008 SHALL have ports is_transmitting (in, 1, UART tx busy), transmit (out, 1, tx start pulse) and tx_byte (out, 8, byte to send).
REQ-009 SHALL have ports blk_valid (out, 1), blk_ready (in, 1), blk_last (out, 1) and blk_data (out, 8*BLOCK_BYTES, byte i at bits [8i+7:8i]).
REQ-010 SHALL have ports dig_valid (in, 1) and dig_data (in, 8*DIGEST_BYTES).
REQ-011 SHALL have port ovf_err  out  1  sticky flag: a byte was dropped.

Function
REQ-012 SHALL delay payload bytes through a 2-byte hold register; a byte is written to the block only when it is shifted out of the hold register and the last 3 received bytes do not equal TERM.
REQ-013 SHALL, when the last 3 received bytes equal TERM, discard all 3 bytes and enter PAD; a partial match followed by a mismatch SHALL release the held bytes as payload.
REQ-014 SHALL count payload bytes in a 32-bit counter; the length field SHALL equal 8*count, little-endian, zero-extended to LEN_BYTES.
REQ-015 SHALL use states COLLECT, PAD, LEN, SEND_BLK, WAIT_DIG, TX_BYTE, TX_WAIT.
REQ-016 COLLECT: when the block index reaches BLOCK_BYTES, go to SEND_BLK with blk_last=0, then return to COLLECT with index 0.
REQ-017 PAD: write 0x80 once, then 0x00 one byte per cycle until index == BLOCK_BYTES-LEN_BYTES; if index exceeds that value after 0x80, zero-fill to BLOCK_BYTES, send with blk_last=0, then continue zero-filling a fresh block.
REQ-018 LEN: write the LEN_BYTES length bytes, then go to SEND_BLK with blk_last=1.
REQ-019 SEND_BLK: hold blk_valid high with blk_data stable until blk_valid&&blk_ready, then clear the block buffer; after the last block, go to WAIT_DIG.
REQ-020 A byte received while not in COLLECT, or during SEND_BLK, SHALL be dropped and SHALL set ovf_err.
REQ-021 WAIT_DIG: on dig_valid, capture dig_data and go to TX_BYTE; dig_valid in any other state SHALL be ignored.
REQ-022 TX_BYTE: when is_transmitting==0, drive tx_byte and pulse transmit for exactly 1 cycle, then go to TX_WAIT.
REQ-023 TX_WAIT: wait for is_transmitting to go 1 and then 0, then send the next byte; after the final byte, clear the counter and return to COLLECT.
REQ-024 SHALL send digest bytes in order dig_data[7:0] first.

Reset
REQ-025 While reset==0: state=COLLECT, counters/index/hold=0, block buffer=0, blk_valid=0, blk_last=0, transmit=0, tx_byte=0, ovf_err=0; asserting reset mid-operation SHALL abandon any message or transmission immediately.

Configuration
REQ-026 With HASH_HEX_OUT_EN defined, each digest byte SHALL be sent as two lowercase ASCII hex characters, high nibble first, followed by 0x0D 0x0A after the last byte (2*DIGEST_BYTES+2 transmits).
REQ-027 Without HASH_HEX_OUT_EN, raw digest bytes SHALL be sent (DIGEST_BYTES transmits).

Structure
REQ-028 The state encoding, the PAD_BYTE (0x80) constant and the nibble-to-ASCII function SHALL reside in package hash_framer_pkg.
REQ-029 The transmit handshake of REQ-022/023 SHALL be implemented as sub-module byte_tx_seq.

Verification
REQ-030 Bytes "EOF" only -> 1 block: byte0=0x80, bytes 1..63=0, blk_last=1; digest d41d8cd98f00b204e9800998ecf8427e returned -> hex mode sends "d41d...427e\r\n".
REQ-031 Bytes "abc" followed by "EOF" -> byte0..2=61 62 63, byte3=0x80, byte56=0x18, bytes 57..63=0.
REQ-032 56 bytes 0x41 followed by "EOF" -> 2 blocks: the first has byte56=0x80 with blk_last=0; the second is all zero except byte56=0xC0 and byte57=0x01, with blk_last=1.
REQ-033 Bytes "EOX" then "EOF" -> 3 payload bytes 45 4F 58, length field=24.
REQ-034 blk_ready held 0 while a byte arrives -> byte dropped, ovf_err=1 until reset.
REQ-035 reset pulsed low during TX_WAIT -> transmit=0 and state=COLLECT; a following "abc" plus "EOF" produces a correct block.

Source files
------------

// File: rtl/hash_framer_pkg.sv
// Shared types and helpers for the UART hash framer: FSM encoding, the pad
// marker byte and nibble-to-ASCII conversion.
package hash_framer_pkg;
  typedef enum logic [2:0] {
    COLLECT, PAD, LEN, SEND_BLK, WAIT_DIG, TX_BYTE, TX_WAIT
  } state_t;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction
endpackage

// File: rtl/byte_tx_seq.sv
// UART transmit handshake: fires a one-cycle transmit pulse when the UART is idle,
// then reports done once the UART has been seen busy and has gone idle again.
module byte_tx_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       wait_en,
  input  logic [7:0] data,
  input  logic       is_transmitting,
  output logic       fired,
  output logic       done,
  output logic       transmit,
  output logic [7:0] tx_byte
);
  logic seen_busy;

  assign fired = go && !is_transmitting;
  assign done  = wait_en && seen_busy && !is_transmitting;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      transmit  <= 1'b0;
      tx_byte   <= '0;
      seen_busy <= 1'b0;
    end else begin
      transmit <= fired;
      if (fired) begin
        tx_byte   <= data;
        seen_busy <= 1'b0;
      end else if (wait_en && is_transmitting) begin
        seen_busy <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_hash_framer.sv
// Frames UART bytes into padded hash blocks terminated by TERM, then returns the
// digest over the UART. Define HASH_HEX_OUT_EN to send the digest as ASCII hex + CRLF.
module uart_hash_framer
  import hash_framer_pkg::*;
#(
  parameter int          BLOCK_BYTES  = 64,
  parameter int          LEN_BYTES    = 8,
  parameter int          DIGEST_BYTES = 16,
  parameter logic [23:0] TERM         = 24'h454F46
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      received,
  input  logic [7:0]                rx_byte,
  input  logic                      is_transmitting,
  output logic                      transmit,
  output logic [7:0]                tx_byte,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic                      blk_last,
  output logic [8*BLOCK_BYTES-1:0]  blk_data,
  input  logic                      dig_valid,
  input  logic [8*DIGEST_BYTES-1:0] dig_data,
  output logic                      ovf_err
);
  localparam int IW = $clog2(BLOCK_BYTES + 1);
  localparam int LW = 8 * LEN_BYTES;
`ifdef HASH_HEX_OUT_EN
  localparam int NTX = 2 * DIGEST_BYTES + 2;
`else
  localparam int NTX = DIGEST_BYTES;
`endif
  localparam int TW = $clog2(NTX + 1);

  state_t                         state, state_n;
  logic [BLOCK_BYTES-1:0][7:0]    blk_buf;
  logic [DIGEST_BYTES-1:0][7:0]   dig_q;
  logic [IW-1:0]                  idx;
  logic [31:0]                    count;
  logic [7:0]                     h0, h1;
  logic [1:0]                     hcnt;
  logic                           pad80;
  logic [TW-1:0]                  tx_idx;
  logic                           wr_en, rx_ok, match, idx_last, blk_fire;
  logic                           tx_fired, tx_done, tx_final;
  logic [7:0]                     wbyte, len_byte, tx_data;
  logic [LW-1:0]                  len_bits;

  assign rx_ok     = received && (state == COLLECT);
  // The two held bytes plus the incoming one form the terminator window.
  assign match     = rx_ok && (hcnt == 2'd2) && ({h1, h0, rx_byte} == TERM);
  assign idx_last  = (idx == IW'(BLOCK_BYTES - 1));
  assign blk_fire  = (state == SEND_BLK) && blk_ready;
  assign tx_final  = (tx_idx == TW'(NTX - 1));
  assign blk_valid = (state == SEND_BLK);
  assign blk_data  = blk_buf;
  assign len_bits  = LW'({count, 3'b000});

  always_comb begin
    len_byte = '0;
    for (int j = 0; j < LEN_BYTES; j++)
      if (idx == IW'(BLOCK_BYTES - LEN_BYTES + j)) len_byte = len_bits[8*j +: 8];
  end

`ifdef HASH_HEX_OUT_EN
  localparam int SW = TW - 1;
  logic [7:0] dsel;
  always_comb begin
    tx_data = 8'h0A;
    dsel    = '0;
    for (int i = 0; i < DIGEST_BYTES; i++)
      if (tx_idx[TW-1:1] == SW'(i)) dsel = dig_q[i];
    if (tx_idx < TW'(2 * DIGEST_BYTES))
      tx_data = hex_char(tx_idx[0] ? dsel[3:0] : dsel[7:4]);
    else if (tx_idx == TW'(2 * DIGEST_BYTES))
      tx_data = 8'h0D;
  end
`else
  always_comb begin
    tx_data = '0;
    for (int i = 0; i < DIGEST_BYTES; i++)
      if (tx_idx == TW'(i)) tx_data = dig_q[i];
  end
`endif

  byte_tx_seq u_tx (
    .clk(clk), .reset(reset),
    .go(state == TX_BYTE), .wait_en(state == TX_WAIT),
    .data(tx_data), .is_transmitting(is_transmitting),
    .fired(tx_fired), .done(tx_done),
    .transmit(transmit), .tx_byte(tx_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    wbyte   = '0;
    case (state)
      COLLECT: begin
        if (match) state_n = PAD;
        else if (rx_ok && hcnt == 2'd2) begin
          wr_en = 1'b1;
          wbyte = h1;
          if (idx_last) state_n = SEND_BLK;
        end
      end
      PAD: begin
        if (!pad80) begin
          wr_en = 1'b1;
          wbyte = PAD_BYTE;
          if (idx_last) state_n = SEND_BLK;
        end else if (idx == IW'(BLOCK_BYTES - LEN_BYTES)) begin
          state_n = LEN;
        end else begin
          // Buffer is already zero, so zero-fill is just an index advance.
          wr_en = 1'b1;
          if (idx_last) state_n = SEND_BLK;
        end
      end
      LEN: begin
        wr_en = 1'b1;
        wbyte = len_byte;
        if (idx_last) state_n = SEND_BLK;
      end
      SEND_BLK: if (blk_ready) state_n = blk_last ? WAIT_DIG : (pad80 ? PAD : COLLECT);
      WAIT_DIG: if (dig_valid) state_n = TX_BYTE;
      TX_BYTE:  if (tx_fired)  state_n = TX_WAIT;
      TX_WAIT:  if (tx_done)   state_n = tx_final ? COLLECT : TX_BYTE;
      default:  state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_buf  <= '0;
      dig_q    <= '0;
      idx      <= '0;
      count    <= '0;
      h0       <= '0;
      h1       <= '0;
      hcnt     <= '0;
      pad80    <= 1'b0;
      blk_last <= 1'b0;
      ovf_err  <= 1'b0;
      tx_idx   <= '0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < BLOCK_BYTES; i++)
          if (idx == IW'(i)) blk_buf[i] <= wbyte;
        idx <= idx + 1'b1;
      end
      if (wr_en && state == COLLECT) count <= count + 32'd1;
      if (match) hcnt <= '0;
      else if (rx_ok) begin
        h1 <= h0;
        h0 <= rx_byte;
        if (hcnt != 2'd2) hcnt <= hcnt + 2'd1;
      end
      if (state == PAD && !pad80)   pad80    <= 1'b1;
      if (state == LEN && idx_last) blk_last <= 1'b1;
      if (blk_fire) begin
        blk_buf  <= '0;
        idx      <= '0;
        blk_last <= 1'b0;
        if (blk_last) pad80 <= 1'b0;
      end
      if (received && state != COLLECT) ovf_err <= 1'b1;
      if (state == WAIT_DIG && dig_valid) begin
        dig_q  <= dig_data;
        tx_idx <= '0;
      end
      if (state == TX_WAIT && tx_done) begin
        if (tx_final) begin
          tx_idx <= '0;
          count  <= '0;
        end else begin
          tx_idx <= tx_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_hash_framer.sv
// Scoreboard bench for uart_hash_framer: stimulus queues expected blocks and
// digest bytes, monitors pop and compare whenever the DUT presents them.
module tb_uart_hash_framer;
  logic         clk = 1'b0, reset = 1'b0;
  logic         received = 1'b0, is_transmitting = 1'b0;
  logic         blk_ready = 1'b1, dig_valid = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic [127:0] dig_data = '0;
  logic         transmit, blk_valid, blk_last, ovf_err;
  logic [7:0]   tx_byte;
  logic [511:0] blk_data;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;

  blk_t       exp_blk[$];
  logic [7:0] exp_tx[$];
  blk_t       mb;
  logic [7:0] mt;
  int         checks = 0, errors = 0;

  localparam logic [127:0] D1 = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D2 = 128'h900150983cd24fb0d6963f7d28e17f72;

  always #5 clk = ~clk;

  uart_hash_framer dut (
    .clk(clk), .reset(reset), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
    .blk_data(blk_data), .dig_valid(dig_valid), .dig_data(dig_data),
    .ovf_err(ovf_err)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (blk_valid && blk_ready) begin
      if (exp_blk.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_block got %0h want none", blk_data);
      end else begin
        mb = exp_blk.pop_front();
        chk("blk_data", blk_data, mb.data);
        chk("blk_last", blk_last, mb.last);
      end
    end
    if (transmit) begin
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_tx got %0h want none", tx_byte);
      end else begin
        mt = exp_tx.pop_front();
        chk("tx_byte", tx_byte, mt);
      end
    end
  end

  // UART model: busy for a few cycles after each transmit pulse
  initial begin
    forever begin
      @(negedge clk);
      if (transmit) begin
        @(posedge clk); #1 is_transmitting = 1'b1;
        repeat (3) @(posedge clk);
        #1 is_transmitting = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b; received = 1'b1;
    tick();
    received = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic push_blk(input logic [511:0] d, input logic l);
    blk_t b;
    b.data = d; b.last = l;
    exp_blk.push_back(b);
  endtask

  task automatic wait_blk(input int budget);
    int n = 0;
    while (exp_blk.size() != 0 && n < budget) begin tick(); n++; end
    checks++;
    if (exp_blk.size() != 0) begin
      errors++;
      $display("FAIL blk_timeout pending %0d want 0", exp_blk.size());
      exp_blk.delete();
    end
  endtask

  task automatic wait_tx(input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin tick(); n++; end
    checks++;
    if (exp_tx.size() != 0) begin
      errors++;
      $display("FAIL tx_timeout pending %0d want 0", exp_tx.size());
      exp_tx.delete();
    end
    tick(10);
  endtask

  // Queue up to ntx expected transmit bytes, then present the digest.
  task automatic give_digest(input logic [127:0] c, input string hex, input int ntx);
    logic [7:0] all[$];
`ifdef HASH_HEX_OUT_EN
    for (int i = 0; i < hex.len(); i++) all.push_back(hex[i]);
    all.push_back(8'h0D);
    all.push_back(8'h0A);
`else
    for (int i = 0; i < 16; i++) all.push_back(c[8*(15-i) +: 8]);
`endif
    for (int i = 0; i < all.size() && (ntx < 0 || i < ntx); i++) exp_tx.push_back(all[i]);
    for (int i = 0; i < 16; i++) dig_data[8*i +: 8] = c[8*(15-i) +: 8];
    tick(2);
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] d, d2;
    int n;
    tick(2);
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_blk_last", blk_last, 1'b0);
    chk("rst_transmit", transmit, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_ovf_err", ovf_err, 1'b0);
    reset = 1'b1;
    tick();

    // digest strobe outside WAIT_DIG must not start a transmission
    dig_data = 128'h0123456789abcdef0123456789abcdef;
    dig_valid = 1'b1; tick(); dig_valid = 1'b0;
    tick(5);

    // "EOF" alone
    d = '0; d[7:0] = 8'h80;
    push_blk(d, 1'b1);
    send_str("EOF");
    wait_blk(200);
    give_digest(D1, "d41d8cd98f00b204e9800998ecf8427e", -1);
    wait_tx(400);

    // "abc" + "EOF"
    d = '0; d[7:0] = 8'h61; d[15:8] = 8'h62; d[23:16] = 8'h63; d[31:24] = 8'h80;
    d[8*56 +: 8] = 8'h18;
    push_blk(d, 1'b1);
    send_str("abcEOF");
    wait_blk(200);
    give_digest(D2, "900150983cd24fb0d6963f7d28e17f72", -1);
    wait_tx(400);

    // 56 x 'A' spills padding into a second block
    d = '0;
    for (int i = 0; i < 56; i++) d[8*i +: 8] = 8'h41;
    d[8*56 +: 8] = 8'h80;
    push_blk(d, 1'b0);
    d2 = '0; d2[8*56 +: 8] = 8'hC0; d2[8*57 +: 8] = 8'h01;
    push_blk(d2, 1'b1);
    for (int i = 0; i < 56; i++) send(8'h41);
    send_str("EOF");
    wait_blk(600);
    give_digest(D1, "d41d8cd98f00b204e9800998ecf8427e", -1);
    wait_tx(400);

    // partial terminator "EOX" is payload
    d = '0; d[7:0] = 8'h45; d[15:8] = 8'h4F; d[23:16] = 8'h58; d[31:24] = 8'h80;
    d[8*56 +: 8] = 8'h18;
    push_blk(d, 1'b1);
    send_str("EOXEOF");
    wait_blk(200);
    give_digest(D2, "900150983cd24fb0d6963f7d28e17f72", -1);
    wait_tx(400);
    chk("ovf_clear_before", ovf_err, 1'b0);

    // byte arriving while a block is stalled is dropped and flagged
    blk_ready = 1'b0;
    d = '0; d[7:0] = 8'h80;
    push_blk(d, 1'b1);
    send_str("EOF");
    n = 0;
    while (!blk_valid && n < 200) begin tick(); n++; end
    chk("stall_blk_valid", blk_valid, 1'b1);
    send(8'h7A);
    chk("ovf_set", ovf_err, 1'b1);
    blk_ready = 1'b1;
    wait_blk(50);
    give_digest(D1, "d41d8cd98f00b204e9800998ecf8427e", -1);
    wait_tx(400);
    chk("ovf_sticky", ovf_err, 1'b1);

    // reset mid-transmission abandons the digest
    d = '0; d[7:0] = 8'h80;
    push_blk(d, 1'b1);
    send_str("EOF");
    wait_blk(200);
    give_digest(D1, "d41d8cd98f00b204e9800998ecf8427e", 1);
    n = 0;
    while (exp_tx.size() != 0 && n < 100) begin tick(); n++; end
    chk("first_tx_seen", exp_tx.size(), 0);
    exp_tx.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_transmit", transmit, 1'b0);
    chk("midrst_blk_valid", blk_valid, 1'b0);
    chk("midrst_ovf_err", ovf_err, 1'b0);
    reset = 1'b1;
    tick(8);
    d = '0; d[7:0] = 8'h61; d[15:8] = 8'h62; d[23:16] = 8'h63; d[31:24] = 8'h80;
    d[8*56 +: 8] = 8'h18;
    push_blk(d, 1'b1);
    send_str("abcEOF");
    wait_blk(200);
    give_digest(D2, "900150983cd24fb0d6963f7d28e17f72", -1);
    wait_tx(400);

    tick(20);
    chk("blk_queue_drained", exp_blk.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
